sha256_io_ctrl: RTL and testbench
=================================

# sha256_io_ctrl

Host-side sequencer between the chip's narrow pin interface and the SHA-256 compression core. Collects sixteen 32-bit words per 512-bit block and launches the core with an init or next command. When the core finishes the last block of a message, it streams the 256-bit digest out of the byte-wide digest pins. It owns `busy` and `output_enable`, so the host needs no knowledge of core latency.

## Interface
- `OUT_W`, default 8: digest output beat width; must divide 256; beats = 256/OUT_W (32 at default).
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `data` in 32: message word from host.
- `write_enable` in 1: host word strobe; word accepted when high and `busy`=0.
- `first_block` in 1: block starts a new message; sampled with word 0.
- `last_block` in 1: block ends the message; sampled with word 0.
- `busy` out 1: high while the controller cannot accept words.
- `digest` out OUT_W: current digest beat, MSB-first.
- `output_enable` out 1: `digest` is valid this cycle.
- `core_block` out 512: assembled block; word 0 in bits [511:480].
- `core_init` out 1: one-cycle pulse, start of a new hash.
- `core_next` out 1: one-cycle pulse, continue the current hash.
- `core_done` in 1: one-cycle pulse from the core, block finished.
- `core_digest` in 256: core hash state; valid when `core_done`=1.

## Operation
- States: LOAD, ISSUE, RUN, SERIAL.
- **LOAD** (`busy`=0)
  - Each accepted word is written to slot `wcnt`; 4-bit `wcnt` increments.
  - On word 0, `first_block` and `last_block` are latched into `f_first` and `f_last`.
  - On word 15, `wcnt` wraps to 0 and the state goes to ISSUE.
- **ISSUE** (one cycle)
  - Pulses `core_init` if `f_first`=1 or `msg_active`=0; otherwise pulses `core_next`.
  - Sets `msg_active`. Goes to RUN.
- **RUN**
  - Waits for `core_done`.
  - On `core_done`: if `f_last`, captures `core_digest` into the shift register and goes to SERIAL; otherwise goes to LOAD.
- **SERIAL**
  - Emits beats[255:256-OUT_W] first, shifting left by OUT_W each cycle.
  - After the final beat: clears `msg_active`, clears the shift register, goes to LOAD.
- `core_block` holds stable from ISSUE until the next word is accepted in LOAD.
- `write_enable` while `busy`=1 is ignored: no slot write, no `wcnt` change.
- `core_done` outside RUN is ignored.
- `first_block` mid-message (`msg_active`=1) forces a `core_init`, which restarts the hash; the prior partial message is discarded.
- `first_block` and `last_block` both high on word 0 is a single-block message: init, then serialize.
- Reset, from any state:
  - State goes to LOAD.
  - `wcnt`=0, `msg_active`=0, `f_first`=0, `f_last`=0.
  - Shift register and `core_block` are cleared to 0.
  - All outputs go to 0: `busy`, `digest`, `output_enable`, `core_init`, `core_next`, `core_block`.
  - A core pulse or serialization in flight is aborted with no further beats.

## Timing
- All outputs are registered.
- Word 15 accepted at edge t:
  - `busy`=1 from t+1.
  - `core_init`/`core_next` high for exactly the cycle t+1 to t+2.
- `core_done` sampled at edge d, non-last block: `busy`=0 from d+1; the next word is acceptable at edge d+1.
- `core_done` sampled at edge d, last block:
  - `output_enable`=1 and beat 0 valid from d+1.
  - Beat k is valid in cycle d+1+k.
  - `output_enable` stays high for exactly 256/OUT_W consecutive cycles.
  - `output_enable`=0 and `busy`=0 from d+1+256/OUT_W.
- Back-to-back operation: no idle cycle is required between a host word and the next.
- The core may take any number of cycles, 1 or more, from the command pulse to `core_done`.
- `digest`=0 whenever `output_enable`=0.

## Test plan
- **Single block, "abc"**
  - Stimulus: words 0x61626380, 0 × 14, 0x00000018; first=last=1; core model.
  - Required: one `core_init`, no `core_next`; `core_block`[511:480]=0x61626380.
  - Required: 32 beats 0xba,0x78,0x16,0xbf,…,0xad; `busy` low 33 cycles after `core_done`.
- **Two-block message**
  - Stimulus: block A with first=1, last=0; then block B with first=0, last=1.
  - Required: `core_init` then `core_next`; `busy` drops between blocks; no `output_enable` after block A; 32 beats after block B.
- **Writes while busy**
  - Stimulus: `write_enable` held high with changing data through ISSUE, RUN and SERIAL.
  - Required: `core_block` unchanged; `wcnt` still 0 when `busy` falls.
- **Core latency sweep**
  - Stimulus: `core_done` delays of 1, 2, 64 and 200 cycles.
  - Required: `output_enable` rises exactly one cycle after `core_done` each time.
  - Stimulus: spurious `core_done` in LOAD. Required: ignored.
- **Reset mid-serialization**
  - Stimulus: assert `reset` at beat 10.
  - Required: next cycle `output_enable`=0, `digest`=0, `busy`=0.
  - Required: the following block issues `core_init` even with first_block=0.
- **Restart mid-message**
  - Stimulus: after a non-last block, send a block with first_block=1.
  - Required: `core_init` (not `core_next`) is pulsed.

Source files
------------

// File: rtl/sha256_io_ctrl.sv
// rtl/sha256_io_ctrl.sv - word collector, core command sequencer and digest serializer for SHA-256
module sha256_io_ctrl #(
    parameter int OUT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        data,
    input  logic               write_enable,
    input  logic               first_block,
    input  logic               last_block,
    output logic               busy,
    output logic [OUT_W-1:0]   digest,
    output logic               output_enable,
    output logic [511:0]       core_block,
    output logic               core_init,
    output logic               core_next,
    input  logic               core_done,
    input  logic [255:0]       core_digest
);

    localparam int BEATS = 256 / OUT_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {LOAD, ISSUE, RUN, SERIAL} state_t;

    state_t         state;
    state_t         state_nx;
    logic [3:0]     wcnt;
    logic           f_first;
    logic           f_last;
    logic           msg_active;
    logic [255:0]   shreg;
    logic [BW-1:0]  bcnt;
    logic           accept;
    logic           last_beat;
    logic           busy_nx;
    logic           init_nx;
    logic           next_nx;

    // Words are only taken in LOAD; busy is the registered image of "not in LOAD"
    assign accept    = (state == LOAD) && write_enable;
    assign last_beat = (bcnt == BW'(BEATS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= LOAD;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    if (accept && wcnt == 4'd15) state_nx = ISSUE;
            ISSUE:   state_nx = RUN;
            RUN:     if (core_done) state_nx = f_last ? SERIAL : LOAD;
            SERIAL:  if (last_beat) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    // Output decode, computed one cycle ahead so every output leaves a flop
    always_comb begin
        busy_nx = (state_nx != LOAD);
        init_nx = 1'b0;
        next_nx = 1'b0;
        if (state == ISSUE) begin
            // A new first block, or no message open, always restarts the hash
            init_nx = f_first || !msg_active;
            next_nx = !(f_first || !msg_active);
        end
    end

    // Registered control outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            busy      <= 1'b0;
            core_init <= 1'b0;
            core_next <= 1'b0;
        end else begin
            busy      <= busy_nx;
            core_init <= init_nx;
            core_next <= next_nx;
        end
    end

    // Block assembly: slot 0 lands in the top word, block flags latch with word 0
    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt       <= 4'd0;
            f_first    <= 1'b0;
            f_last     <= 1'b0;
            core_block <= '0;
        end else if (accept) begin
            core_block[{~wcnt, 5'b0} +: 32] <= data;
            wcnt <= wcnt + 4'd1;
            if (wcnt == 4'd0) begin
                f_first <= first_block;
                f_last  <= last_block;
            end
        end
    end

    // Message-open flag: set on each issue, dropped once the digest is out
    always_ff @(posedge clk) begin
        if (reset)                         msg_active <= 1'b0;
        else if (state == ISSUE)           msg_active <= 1'b1;
        else if (state == SERIAL && last_beat) msg_active <= 1'b0;
    end

    // Digest serializer: beat 0 is presented on the capture edge, shreg holds the rest
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg         <= '0;
            digest        <= '0;
            output_enable <= 1'b0;
            bcnt          <= '0;
        end else if (state == RUN && core_done && f_last) begin
            shreg         <= core_digest << OUT_W;
            digest        <= core_digest[255 -: OUT_W];
            output_enable <= 1'b1;
            bcnt          <= '0;
        end else if (state == SERIAL) begin
            if (last_beat) begin
                shreg         <= '0;
                digest        <= '0;
                output_enable <= 1'b0;
                bcnt          <= '0;
            end else begin
                shreg  <= shreg << OUT_W;
                digest <= shreg[255 -: OUT_W];
                bcnt   <= bcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sha256_io_ctrl.sv
// tb/tb_sha256_io_ctrl.sv - directed self-checking bench for sha256_io_ctrl
module tb_sha256_io_ctrl;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  data = '0;
    logic         write_enable = 1'b0;
    logic         first_block = 1'b0;
    logic         last_block = 1'b0;
    logic         busy;
    logic [7:0]   digest;
    logic         output_enable;
    logic [511:0] core_block;
    logic         core_init;
    logic         core_next;
    logic         core_done;
    logic [255:0] core_digest = '0;
    logic         model_done = 1'b0;
    logic         spur_done = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int core_lat = 3;
    int done_cyc = 0;
    int init_cnt = 0;
    int next_cnt = 0;
    int oe_cnt = 0;
    logic [255:0] dig_val = '0;
    logic [31:0]  blk [16];

    localparam logic [255:0] ABC_DIG =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_B =
        256'h0123456789abcdeffedcba9876543210a5a5a5a55a5a5a5a00ff00ff11223344;

    assign core_done = model_done | spur_done;

    sha256_io_ctrl #(.OUT_W(8)) dut (
        .clk(clk), .reset(reset), .data(data), .write_enable(write_enable),
        .first_block(first_block), .last_block(last_block), .busy(busy),
        .digest(digest), .output_enable(output_enable), .core_block(core_block),
        .core_init(core_init), .core_next(core_next), .core_done(core_done),
        .core_digest(core_digest)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (core_init) init_cnt <= init_cnt + 1;
        if (core_next) next_cnt <= next_cnt + 1;
        if (output_enable) oe_cnt <= oe_cnt + 1;
    end

    // Core model: done pulse core_lat cycles after a command
    initial begin
        forever begin
            @(negedge clk);
            if (core_init || core_next) begin
                repeat (core_lat - 1) @(negedge clk);
                model_done = 1'b1;
                core_digest = dig_val;
                done_cyc = cyc;
                @(negedge clk);
                model_done = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] blk_vec();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[511 - 32*i -: 32] = blk[i];
        return v;
    endfunction

    task automatic fill_blk(input logic [31:0] seed);
        for (int i = 0; i < 16; i++) blk[i] = seed ^ (32'h01010101 * i);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (busy) check({tag, "_idle_timeout"}, 1, 0);
    endtask

    // Sixteen back-to-back words; returns at the negedge after word 15 is taken
    task automatic send_block(input logic first, input logic last, input string tag);
        wait_idle(tag);
        for (int i = 0; i < 16; i++) begin
            write_enable = 1'b1;
            data = blk[i];
            first_block = (i == 0) ? first : 1'b0;
            last_block  = (i == 0) ? last : 1'b0;
            @(negedge clk);
        end
        write_enable = 1'b0;
        data = '0;
        check({tag, "_busy_after_w15"}, busy, 1);
        check({tag, "_block"}, core_block, blk_vec());
    endtask

    task automatic wait_digest(input logic [255:0] exp, input string tag);
        int n = 0;
        int miss = 0;
        logic [255:0] acc = '0;
        while (!output_enable && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!output_enable) begin
            check({tag, "_oe_timeout"}, 0, 1);
            return;
        end
        check({tag, "_oe_latency"}, cyc, done_cyc + 1);
        for (int i = 0; i < 32; i++) begin
            if (!output_enable || !busy) miss++;
            acc = {acc[247:0], digest};
            @(negedge clk);
        end
        check({tag, "_beats_valid"}, miss, 0);
        check({tag, "_digest"}, acc, exp);
        check({tag, "_oe_end"}, {output_enable, busy, digest}, 0);
    endtask

    initial begin
        int i0, n0, o0;
        logic [511:0] held;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, output_enable, digest, core_init, core_next}, 0);
        check("reset_block", core_block, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single block "abc"
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0] = 32'h61626380;
        blk[15] = 32'h00000018;
        dig_val = ABC_DIG;
        core_lat = 3;
        i0 = init_cnt; n0 = next_cnt;
        send_block(1'b1, 1'b1, "abc");
        check("abc_init_pre", core_init, 0);
        @(negedge clk);
        check("abc_init_pulse", {core_init, core_next}, 2'b10);
        check("abc_word0", core_block[511:480], 32'h61626380);
        @(negedge clk);
        check("abc_init_drop", core_init, 0);
        wait_digest(ABC_DIG, "abc");
        check("abc_cmds", {init_cnt - i0, next_cnt - n0}, {32'd1, 32'd0});

        // Two-block message
        i0 = init_cnt; n0 = next_cnt;
        fill_blk(32'hA0000000);
        dig_val = 256'h1111;
        send_block(1'b1, 1'b0, "twoA");
        o0 = oe_cnt;
        wait_idle("twoA");
        check("twoA_busy_drop", busy, 0);
        fill_blk(32'hB0000000);
        dig_val = DIG_B;
        send_block(1'b0, 1'b1, "twoB");
        check("twoA_no_oe", oe_cnt - o0, 0);
        wait_digest(DIG_B, "twoB");
        check("two_cmds", {init_cnt - i0, next_cnt - n0}, {32'd1, 32'd1});

        // Writes while busy
        fill_blk(32'hC0000000);
        dig_val = ABC_DIG;
        core_lat = 5;
        send_block(1'b1, 1'b1, "wb");
        held = blk_vec();
        begin
            int n = 0;
            write_enable = 1'b1;
            while (busy && n < 600) begin
                data = $urandom;
                @(negedge clk);
                n++;
            end
            write_enable = 1'b0;
            check("wb_busy_fell", busy, 0);
        end
        check("wb_block_held", core_block, held);
        fill_blk(32'hD0000000);
        send_block(1'b1, 1'b1, "wb2");
        wait_digest(ABC_DIG, "wb2");

        // Spurious core_done in LOAD
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        @(negedge clk);
        check("spur_ignored", {busy, output_enable}, 0);

        // Latency sweep
        foreach (blk[k]) blk[k] = 32'h5 + k;
        dig_val = DIG_B;
        core_lat = 1;   send_block(1'b1, 1'b1, "lat1");   wait_digest(DIG_B, "lat1");
        core_lat = 2;   send_block(1'b1, 1'b1, "lat2");   wait_digest(DIG_B, "lat2");
        core_lat = 64;  send_block(1'b1, 1'b1, "lat64");  wait_digest(DIG_B, "lat64");
        core_lat = 200; send_block(1'b1, 1'b1, "lat200"); wait_digest(DIG_B, "lat200");

        // Reset mid-serialization
        core_lat = 4;
        fill_blk(32'hE0000000);
        send_block(1'b1, 1'b1, "rst");
        begin
            int n = 0;
            while (!output_enable && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_outputs", {output_enable, digest, busy}, 0);
        reset = 1'b0;
        @(negedge clk);
        i0 = init_cnt; n0 = next_cnt;
        send_block(1'b0, 1'b1, "rst2");
        wait_digest(DIG_B, "rst2");
        check("rst2_cmds", {init_cnt - i0, next_cnt - n0}, {32'd1, 32'd0});

        // Restart mid-message
        i0 = init_cnt; n0 = next_cnt;
        fill_blk(32'hF0000000);
        send_block(1'b1, 1'b0, "rsA");
        wait_idle("rsA");
        dig_val = ABC_DIG;
        fill_blk(32'hF1000000);
        send_block(1'b1, 1'b1, "rsB");
        wait_digest(ABC_DIG, "rsB");
        check("restart_cmds", {init_cnt - i0, next_cnt - n0}, {32'd2, 32'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
